// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU op codes, opcodes,
// funct codes and FSM state numbers. The ALU imports the same package.
package mips_multicycle_control_pkg;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_XOR = 3'b010;
    localparam logic [2:0] ALUOP_NOR = 3'b011;
    localparam logic [2:0] ALUOP_SLT = 3'b100;
    localparam logic [2:0] ALUOP_ADD = 3'b101;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_MOD = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_SLTI  = 6'h0a;

    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_MOD = 6'h1a;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_MOD_WAIT = 4'd3;
    localparam logic [3:0] ST_RWB      = 4'd4;
    localparam logic [3:0] ST_EXEC_I   = 4'd5;
    localparam logic [3:0] ST_IWB      = 4'd6;
    localparam logic [3:0] ST_MEMADDR  = 4'd7;
    localparam logic [3:0] ST_MEMRD    = 4'd8;
    localparam logic [3:0] ST_MEMWB    = 4'd9;
    localparam logic [3:0] ST_MEMWR    = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;

    typedef struct packed {
        logic [2:0] aluop;
        logic       is_mod;
        logic       valid;
    } alu_dec_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
    } ctrl_t;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            OP_SLTI: return ALUOP_SLT;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle: IR fields and status in, ALU op and enables out.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output aluop, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_read,
               mem_write, iord, mem_to_reg, reg_dst, reg_write, illegal, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  aluop, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_read,
               mem_write, iord, mem_to_reg, reg_dst, reg_write, illegal, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_control_alu_op_decoder.sv
// R-type funct decode: ALU op, whether it is the multicycle mod, and validity.
module alu_op_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output alu_dec_t   dec
);
    always_comb begin
        dec = '{aluop: ALUOP_AND, is_mod: 1'b0, valid: 1'b1};
        case (funct)
            FUNCT_AND: dec.aluop = ALUOP_AND;
            FUNCT_OR:  dec.aluop = ALUOP_OR;
            FUNCT_XOR: dec.aluop = ALUOP_XOR;
            FUNCT_NOR: dec.aluop = ALUOP_NOR;
            FUNCT_SLT: dec.aluop = ALUOP_SLT;
            FUNCT_ADD: dec.aluop = ALUOP_ADD;
            FUNCT_SUB: dec.aluop = ALUOP_SUB;
            FUNCT_MOD: begin
                dec.aluop  = ALUOP_MOD;
                dec.is_mod = 1'b1;
            end
            default:   dec.valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences one instruction at a time and drives
// the ALU op plus datapath enables; mod holds operands for MOD_CYCLES cycles.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int MOD_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_multicycle_control_if.master  bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MOD_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    alu_dec_t         fdec;
    ctrl_t            ctrl;

    alu_op_decoder u_dec (.funct(bus.funct), .dec(fdec));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH: if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                          state_d = ST_EXEC_R;
                    OP_LW, OP_SW:                      state_d = ST_MEMADDR;
                    OP_BEQ, OP_BNE:                    state_d = ST_BRANCH;
                    OP_J:                              state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_EXEC_I;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R: begin
                if (!fdec.valid) begin
                    state_d   = ST_FETCH;
                    illegal_d = 1'b1;
                end else if (fdec.is_mod) begin
                    state_d = ST_MOD_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_RWB;
                end
            end
            // Counter reads 0 on the last of MOD_CYCLES residency cycles.
            ST_MOD_WAIT: begin
                if (cnt_q == '0) state_d = ST_RWB;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_EXEC_I:  state_d = ST_IWB;
            ST_MEMADDR: state_d = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   if (bus.mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:   if (bus.mem_ready) state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // IR is stable after FETCH, so opcode/funct can steer later-state outputs.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                ctrl.aluop     = ALUOP_ADD;
                ctrl.alu_src_b = 2'b11;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.aluop     = fdec.aluop;
            end
            ST_MOD_WAIT: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.aluop     = ALUOP_MOD;
            end
            ST_RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.aluop     = imm_aluop(bus.opcode);
            end
            ST_IWB: ctrl.reg_write = 1'b1;
            ST_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.aluop     = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_write  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
            end
            ST_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
        if (rst) ctrl = '0;
    end

    assign bus.aluop      = ctrl.aluop;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.illegal    = rst ? 1'b0 : illegal_q;
    assign bus.state_dbg  = rst ? ST_FETCH : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench: an instruction-level model expands each instruction into
// expected per-cycle outputs (with a care mask) and the DUT is compared cycle by cycle.
module tb_mips_multicycle_control;
    localparam int MODC = 4;

    typedef struct packed {
        logic [2:0] aluop;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       illegal;
        logic       in_fetch;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        logic       z;
        obs_t       exp;
        obs_t       mask;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    step_t q[$];
    step_t done[$];
    obs_t  act[$];
    obs_t  e, m;
    logic  pend_ill = 1'b0;
    logic [5:0] cur_op, cur_fn;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.MOD_CYCLES(MODC), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Funct table: ALU code, or -1 for an undecodable funct.
    function automatic int ref_funct(input logic [5:0] f);
        case (f)
            6'h24: return 0;
            6'h25: return 1;
            6'h26: return 2;
            6'h27: return 3;
            6'h2a: return 4;
            6'h20: return 5;
            6'h22: return 6;
            6'h1a: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic obs_t obs_now();
        obs_t o;
        o.aluop = bus.aluop;       o.src_a = bus.alu_src_a;   o.src_b = bus.alu_src_b;
        o.pc_src = bus.pc_src;     o.pc_write = bus.pc_write; o.ir_write = bus.ir_write;
        o.mem_read = bus.mem_read; o.mem_write = bus.mem_write; o.iord = bus.iord;
        o.mem_to_reg = bus.mem_to_reg; o.reg_dst = bus.reg_dst; o.reg_write = bus.reg_write;
        o.illegal = bus.illegal;   o.in_fetch = (bus.state_dbg == 4'd0);
        return o;
    endfunction

    function automatic logic [20:0] all_outs();
        return {bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_write, bus.ir_write,
                bus.mem_read, bus.mem_write, bus.iord, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                bus.illegal, bus.state_dbg};
    endfunction

    task automatic begin_cyc();
        e = '0; m = '0;
        m.pc_write = 1; m.ir_write = 1; m.mem_read = 1; m.mem_write = 1;
        m.reg_write = 1; m.illegal = 1; m.in_fetch = 1;
    endtask

    task automatic set_alu(input logic [2:0] op, input logic sa, input logic [1:0] sb);
        e.aluop = op; m.aluop = '1; e.src_a = sa; m.src_a = 1; e.src_b = sb; m.src_b = '1;
    endtask

    task automatic push(input logic mr, input logic z);
        step_t s;
        s.op = cur_op; s.fn = cur_fn; s.mr = mr; s.z = z; s.exp = e; s.mask = m;
        q.push_back(s);
    endtask

    // fd = FETCH cycles without mem_ready, md = same for the data access.
    task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                               input int md, input logic z);
        int a;
        cur_op = op; cur_fn = fn;
        for (int i = 0; i <= fd; i++) begin
            begin_cyc(); set_alu(3'b101, 1'b0, 2'b01);
            e.mem_read = 1; m.iord = 1; e.in_fetch = 1;
            if (i == 0) e.illegal = pend_ill;
            if (i == fd) begin e.ir_write = 1; e.pc_write = 1; m.pc_src = '1; end
            push(i == fd, rbit());
        end
        pend_ill = 0;
        begin_cyc(); set_alu(3'b101, 1'b0, 2'b11); push(rbit(), rbit());
        case (op)
            6'h00: begin
                a = ref_funct(fn);
                begin_cyc(); e.src_a = 1; m.src_a = 1; m.src_b = '1;
                if (a >= 0) begin e.aluop = 3'(a); m.aluop = '1; end
                push(rbit(), rbit());
                if (a < 0) pend_ill = 1;
                else begin
                    if (a == 7)
                        for (int i = 0; i < MODC; i++) begin
                            begin_cyc(); set_alu(3'b111, 1'b1, 2'b00); push(rbit(), rbit());
                        end
                    begin_cyc(); e.reg_dst = 1; m.reg_dst = 1; m.mem_to_reg = 1; e.reg_write = 1;
                    push(rbit(), rbit());
                end
            end
            6'h23, 6'h2b: begin
                begin_cyc(); set_alu(3'b101, 1'b1, 2'b10); push(rbit(), rbit());
                for (int i = 0; i <= md; i++) begin
                    begin_cyc(); e.iord = 1; m.iord = 1;
                    if (op == 6'h23) e.mem_read = 1; else e.mem_write = 1;
                    push(i == md, rbit());
                end
                if (op == 6'h23) begin
                    begin_cyc(); m.reg_dst = 1; e.mem_to_reg = 1; m.mem_to_reg = 1; e.reg_write = 1;
                    push(rbit(), rbit());
                end
            end
            6'h04, 6'h05: begin
                begin_cyc(); set_alu(3'b110, 1'b1, 2'b00); e.pc_src = 2'b01; m.pc_src = '1;
                e.pc_write = (op == 6'h04) ? z : ~z;
                push(rbit(), z);
            end
            6'h02: begin
                begin_cyc(); e.pc_src = 2'b10; m.pc_src = '1; e.pc_write = 1; push(rbit(), rbit());
            end
            6'h08, 6'h0c, 6'h0d, 6'h0a: begin
                begin_cyc();
                set_alu(op == 6'h08 ? 3'b101 : op == 6'h0c ? 3'b000 : op == 6'h0d ? 3'b001 : 3'b100,
                        1'b1, 2'b10);
                push(rbit(), rbit());
                begin_cyc(); m.reg_dst = 1; e.reg_write = 1; push(rbit(), rbit());
            end
            default: pend_ill = 1;
        endcase
    endtask

    task automatic start();
        q.delete(); done.delete(); act.delete();
    endtask

    task automatic drive(input int limit);
        step_t s;
        int n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            bus.opcode = s.op; bus.funct = s.fn; bus.mem_ready = s.mr; bus.zero = s.z;
            @(negedge clk);
            act.push_back(obs_now());
            done.push_back(s);
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
            bus.mem_ready = 1'b1; bus.zero = rbit();
            @(negedge clk);
            vectors++;
            if (all_outs() !== '0) begin
                miscompares++;
                $display("FAIL reset cyc %0d outs=%h want=0", i, all_outs());
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        pend_ill = 1'b0;
    endtask

    task automatic test_add();
        int rw = 0;
        start(); build_instr(6'h00, 6'h20, 0, 0, 1'b0); drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL add cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
            rw += int'(act[i].reg_write);
        end
        vectors++;
        if (act.size() != 4 || rw != 1 || act[2].aluop !== 3'b101) begin
            miscompares++;
            $display("FAIL add_shape cycles=%0d want 4 reg_writes=%0d want 1", act.size(), rw);
        end
    endtask

    task automatic test_mod();
        int rw = 0, mods = 0;
        start(); build_instr(6'h00, 6'h1a, 1, 0, 1'b0); drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL mod cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
            rw += int'(act[i].reg_write);
            mods += int'(act[i].aluop == 3'b111 && !act[i].in_fetch);
        end
        vectors++;
        if (rw != 1 || mods != MODC + 1) begin
            miscompares++;
            $display("FAIL mod_count reg_writes=%0d want 1 aluop111_cycles=%0d want %0d", rw, mods, MODC + 1);
        end
    endtask

    task automatic test_lw_wait();
        int rd = 0;
        start(); build_instr(6'h23, 6'h00, 0, 3, 1'b0); drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL lw cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
            rd += int'(act[i].mem_read && act[i].iord);
        end
        vectors++;
        if (rd != 4 || !(act[act.size()-1].mem_to_reg && act[act.size()-1].reg_write)) begin
            miscompares++;
            $display("FAIL lw_hold data_read_cycles=%0d want 4", rd);
        end
    endtask

    task automatic test_branch();
        start();
        build_instr(6'h04, 6'h00, 0, 0, 1'b1);
        build_instr(6'h05, 6'h00, 0, 0, 1'b1);
        build_instr(6'h05, 6'h00, 2, 0, 1'b0);
        build_instr(6'h04, 6'h00, 0, 0, 1'b0);
        build_instr(6'h02, 6'h00, 0, 0, 1'b0);
        drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL branch cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
        end
        vectors++;
        if (act[2].pc_write !== 1'b1 || act[2].pc_src !== 2'b01 || act[5].pc_write !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_bne beq_pcw=%b want 1 bne_pcw=%b want 0", act[2].pc_write, act[5].pc_write);
        end
    endtask

    task automatic test_illegal();
        int wr = 0;
        start();
        build_instr(6'h3f, 6'h00, 0, 0, 1'b0);
        build_instr(6'h00, 6'h3f, 0, 0, 1'b0);
        build_instr(6'h2b, 6'h00, 0, 1, 1'b0);
        drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL illegal cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
            if (i < 6) wr += int'(act[i].reg_write || act[i].mem_write);
        end
        vectors++;
        if (act[2].illegal !== 1'b1 || act[2].in_fetch !== 1'b1 || wr != 0) begin
            miscompares++;
            $display("FAIL illegal_pulse ill=%b want 1 fetch=%b want 1 writes=%0d want 0",
                     act[2].illegal, act[2].in_fetch, wr);
        end
    endtask

    task automatic test_reset_mod_wait();
        start(); build_instr(6'h00, 6'h1a, 0, 0, 1'b0); drive(5);
        rst = 1'b1; bus.mem_ready = rbit();
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL rst_mod outs=%h want=0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0; pend_ill = 1'b0;
        start(); build_instr(6'h08, 6'h00, 0, 0, 1'b0); drive(100);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL rst_resume cyc %0d act=%h exp=%h mask=%h", i, act[i], done[i].exp, done[i].mask);
            end
        end
        vectors++;
        if (act[0].mem_read !== 1'b1 || act[0].in_fetch !== 1'b1 || act[0].reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_fetch mem_read=%b want 1 reg_write=%b want 0", act[0].mem_read, act[0].reg_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c, 6'h0d};
        logic [5:0] fns[8]  = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h20, 6'h22, 6'h1a};
        logic [5:0] op, fn;
        start();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 12))
                11:      op = 6'h0a;
                12:      op = 6'($urandom);
                default: op = ops[$urandom_range(0, 10)];
            endcase
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            build_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        end
        drive(100000);
        foreach (act[i]) begin
            vectors++;
            if (((act[i] ^ done[i].exp) & done[i].mask) !== '0 || (act[i].reg_write && act[i].mem_write)) begin
                miscompares++;
                $display("FAIL random cyc %0d op=%h fn=%h act=%h exp=%h mask=%h",
                         i, done[i].op, done[i].fn, act[i], done[i].exp, done[i].mask);
            end
        end
    endtask

    initial begin
        bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        test_reset();
        test_add();
        test_mod();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_reset_mod_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
